// File: rtl/pipo_load_arbiter_if.sv
// Bundle between requesters and the shared-register arbiter.
// The arbiter takes the slave modport; the requester side takes master.
interface pipo_load_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) ();
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] x;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [2:0]            owner;
  logic                  q_valid;
  logic                  busy;

  modport master (
    output req, x,
    input  gnt, q, owner, q_valid, busy
  );

  modport slave (
    input  req, x,
    output gnt, q, owner, q_valid, busy
  );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter loading one requester word per grant into a shared
// holding register, followed by a fixed hold window before the next grant.
module pipo_load_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int HOLD  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pipo_load_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {S_IDLE, S_HOLD} state_t;

  localparam logic       HAS_HOLD = (HOLD > 0);
  localparam logic [3:0] HOLD_CNT = 4'(HOLD);

  state_t           r_state;
  state_t           w_state_nx;
  logic [2:0]       r_ptr;
  logic [2:0]       r_owner;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;

  logic             w_found;
  logic [2:0]       w_gidx;
  logic [2:0]       w_cand;
  logic [7:0]       w_req8;
  logic [7:0]       w_gnt8;
  logic [WIDTH-1:0] w_xsel;
  logic             w_load;

  function automatic logic [2:0] wrap_add(input logic [2:0] base,
                                          input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 4'(NREQ)) s = s - 4'(NREQ);
    return s[2:0];
  endfunction

  assign w_req8 = 8'(bus.req);

  // Scan starts at ptr; the grant is suppressed outside IDLE and during reset.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    if (r_state == S_IDLE && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        w_cand = wrap_add(r_ptr, 3'(k));
        if (!w_found && w_req8[w_cand]) begin
          w_found = 1'b1;
          w_gidx  = w_cand;
        end
      end
    end
  end

  always_comb begin
    w_xsel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == 3'(i)) w_xsel = bus.x[i*WIDTH +: WIDTH];
    end
  end

  assign w_gnt8 = w_found ? (8'd1 << w_gidx) : 8'd0;

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_load = 1'b1;
          if (HAS_HOLD) w_state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == 4'd1) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      r_owner   <= '0;
      r_q_valid <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      r_q_valid <= w_load;
      if (w_load) begin
        r_q     <= w_xsel;
        r_owner <= w_gidx;
        r_ptr   <= wrap_add(w_gidx, 3'd1);
        r_cnt   <= HOLD_CNT;
      end else if (r_state == S_HOLD) begin
        r_cnt   <= r_cnt - 4'd1;
      end
    end
  end

  assign bus.gnt     = w_gnt8[NREQ-1:0];
  assign bus.q       = r_q;
  assign bus.owner   = r_owner;
  assign bus.q_valid = r_q_valid;
  assign bus.busy    = (r_state == S_HOLD);

endmodule
